// File: rtl/cmip_mem_sfifo_ctrl.sv
// Single-clock FIFO controller for a 1r1w memory macro with fixed read latency.
// A small register output buffer, backed by read credits, gives a full-rate valid/ready output.
module cmip_mem_sfifo_ctrl #(
  parameter int DPTH         = 1024,
  parameter int DATA_WDTH    = 32,
  parameter int ADDR_WDTH    = $clog2(DPTH),
  parameter int READ_LATENCY = 4,
  localparam int OBUF_DPTH   = READ_LATENCY + 2,
  localparam int CNT_WDTH    = $clog2(DPTH + OBUF_DPTH + 1)
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_wvalid,
  output logic                 o_wready,
  input  logic [DATA_WDTH-1:0] i_wdata,
  output logic                 o_rvalid,
  input  logic                 i_rready,
  output logic [DATA_WDTH-1:0] o_rdata,
  output logic                 o_mem_wr,
  output logic [ADDR_WDTH-1:0] o_mem_waddr,
  output logic [DATA_WDTH-1:0] o_mem_wdata,
  output logic                 o_mem_rd,
  output logic [ADDR_WDTH-1:0] o_mem_raddr,
  input  logic [DATA_WDTH-1:0] i_mem_rdata,
  output logic [CNT_WDTH-1:0]  o_data_cnt,
  output logic                 o_overflow
);

  localparam int MCNT_WDTH = ADDR_WDTH + 1;
  localparam int ICNT_WDTH = $clog2(READ_LATENCY + 1);
  localparam int OCNT_WDTH = $clog2(OBUF_DPTH + 1);
  localparam int OPTR_WDTH = $clog2(OBUF_DPTH);

  function automatic logic [ICNT_WDTH-1:0] f_popcnt(input logic [READ_LATENCY-1:0] i_vec);
    logic [ICNT_WDTH-1:0] v_cnt;
    v_cnt = '0;
    for (int i = 0; i < READ_LATENCY; i++) begin
      v_cnt = v_cnt + ICNT_WDTH'(i_vec[i]);
    end
    return v_cnt;
  endfunction

  function automatic logic [OPTR_WDTH-1:0] f_optr_inc(input logic [OPTR_WDTH-1:0] i_ptr);
    return (i_ptr == OPTR_WDTH'(OBUF_DPTH - 1)) ? '0 : i_ptr + OPTR_WDTH'(1);
  endfunction

  logic [ADDR_WDTH-1:0]    r_wptr;
  logic [ADDR_WDTH-1:0]    r_rptr;
  logic [MCNT_WDTH-1:0]    r_mem_cnt;
  logic [READ_LATENCY-1:0] r_inflight;
  logic [DATA_WDTH-1:0]    r_obuf [OBUF_DPTH];
  logic [OPTR_WDTH-1:0]    r_ob_head;
  logic [OPTR_WDTH-1:0]    r_ob_tail;
  logic [OCNT_WDTH-1:0]    r_ob_cnt;
  logic [CNT_WDTH-1:0]     r_data_cnt;
  logic                    r_overflow;

  logic                    w_wready;
  logic                    w_wr;
  logic                    w_rd;
  logic                    w_push;
  logic                    w_pop;
  logic                    w_rvalid;
  logic [READ_LATENCY-1:0] w_inflight_nxt;
  logic [MCNT_WDTH-1:0]    w_mem_cnt_nxt;
  logic [OCNT_WDTH-1:0]    w_ob_cnt_nxt;
  logic [CNT_WDTH-1:0]     w_credit_used;

  assign w_wready = (r_mem_cnt != MCNT_WDTH'(DPTH));
  assign w_wr     = i_wvalid & w_wready;

  // Every issued read owns an output-buffer slot until popped; a same-cycle pop frees nothing yet.
  assign w_credit_used = CNT_WDTH'(f_popcnt(r_inflight)) + CNT_WDTH'(r_ob_cnt);
  assign w_rd          = (r_mem_cnt != '0) && (w_credit_used < CNT_WDTH'(OBUF_DPTH));

  assign w_push   = r_inflight[READ_LATENCY-1];
  assign w_rvalid = (r_ob_cnt != '0);
  assign w_pop    = i_rready & w_rvalid;

  assign w_mem_cnt_nxt = r_mem_cnt + MCNT_WDTH'(w_wr) - MCNT_WDTH'(w_rd);
  assign w_ob_cnt_nxt  = r_ob_cnt + OCNT_WDTH'(w_push) - OCNT_WDTH'(w_pop);

  if (READ_LATENCY == 1) begin : g_rl_one
    assign w_inflight_nxt = w_rd;
  end else begin : g_rl_multi
    assign w_inflight_nxt = {r_inflight[READ_LATENCY-2:0], w_rd};
  end

  // Pointers, occupancy counters, in-flight tracking and status outputs.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_mem_cnt  <= '0;
      r_inflight <= '0;
      r_ob_head  <= '0;
      r_ob_tail  <= '0;
      r_ob_cnt   <= '0;
      r_data_cnt <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_wr) r_wptr <= r_wptr + ADDR_WDTH'(1);
      if (w_rd) r_rptr <= r_rptr + ADDR_WDTH'(1);
      if (w_push) r_ob_tail <= f_optr_inc(r_ob_tail);
      if (w_pop) r_ob_head <= f_optr_inc(r_ob_head);
      r_mem_cnt  <= w_mem_cnt_nxt;
      r_inflight <= w_inflight_nxt;
      r_ob_cnt   <= w_ob_cnt_nxt;
      r_data_cnt <= CNT_WDTH'(w_mem_cnt_nxt) + CNT_WDTH'(f_popcnt(w_inflight_nxt))
                    + CNT_WDTH'(w_ob_cnt_nxt);
      r_overflow <= i_wvalid & ~w_wready;
    end
  end

  // Output buffer storage; returning read data lands at the tail.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < OBUF_DPTH; i++) begin
        r_obuf[i] <= '0;
      end
    end else begin
      if (w_push) r_obuf[r_ob_tail] <= i_mem_rdata;
    end
  end

  assign o_wready    = w_wready;
  assign o_rvalid    = w_rvalid;
  assign o_rdata     = w_rvalid ? r_obuf[r_ob_head] : '0;
  assign o_mem_wr    = w_wr;
  assign o_mem_waddr = r_wptr;
  assign o_mem_wdata = i_wdata;
  assign o_mem_rd    = w_rd;
  assign o_mem_raddr = r_rptr;
  assign o_data_cnt  = r_data_cnt;
  assign o_overflow  = r_overflow;

endmodule

// File: tb/tb_cmip_mem_sfifo_ctrl.sv
// Bench for cmip_mem_sfifo_ctrl: memory macro model plus a queue-based scoreboard of accepted words.
module tb_cmip_mem_sfifo_ctrl;

  localparam int DPTH = 1024;
  localparam int DW   = 32;
  localparam int AW   = 10;
  localparam int RL   = 4;
  localparam int OBUF = RL + 2;
  localparam int CW   = $clog2(DPTH + OBUF + 1);

  logic          i_clk    = 1'b0;
  logic          i_rst_n  = 1'b1;
  logic          i_wvalid = 1'b0;
  logic          i_rready = 1'b0;
  logic [DW-1:0] i_wdata  = '0;
  logic          o_wready;
  logic          o_rvalid;
  logic [DW-1:0] o_rdata;
  logic          o_mem_wr;
  logic [AW-1:0] o_mem_waddr;
  logic [DW-1:0] o_mem_wdata;
  logic          o_mem_rd;
  logic [AW-1:0] o_mem_raddr;
  logic [DW-1:0] i_mem_rdata;
  logic [CW-1:0] o_data_cnt;
  logic          o_overflow;

  cmip_mem_sfifo_ctrl #(.DPTH(DPTH), .DATA_WDTH(DW), .ADDR_WDTH(AW), .READ_LATENCY(RL)) u_dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n),
    .i_wvalid(i_wvalid), .o_wready(o_wready), .i_wdata(i_wdata),
    .o_rvalid(o_rvalid), .i_rready(i_rready), .o_rdata(o_rdata),
    .o_mem_wr(o_mem_wr), .o_mem_waddr(o_mem_waddr), .o_mem_wdata(o_mem_wdata),
    .o_mem_rd(o_mem_rd), .o_mem_raddr(o_mem_raddr), .i_mem_rdata(i_mem_rdata),
    .o_data_cnt(o_data_cnt), .o_overflow(o_overflow)
  );

  always #5 i_clk = ~i_clk;

  // Memory macro: a read sampled at an edge is presented READ_LATENCY edges later.
  logic [DW-1:0] mem     [DPTH];
  logic [DW-1:0] rd_pipe [RL];
  always @(posedge i_clk) begin
    if (o_mem_wr) mem[o_mem_waddr] <= o_mem_wdata;
    rd_pipe[0] <= o_mem_rd ? mem[o_mem_raddr] : '0;
    for (int k = 1; k < RL; k++) rd_pipe[k] <= rd_pipe[k-1];
  end
  assign i_mem_rdata = rd_pipe[RL-1];

  int            n_chk  = 0;
  int            n_pass = 0;
  logic [DW-1:0] q[$];
  logic          stall_r = 1'b0;
  logic [DW-1:0] stall_data = '0;
  logic          pre_rvalid = 1'b0;
  logic          last_acc = 1'b0;
  int            n_written = 0;
  int            n_popped = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
  endtask

  // One clock: drive, check handshake-side rules, advance the model, check registered outputs.
  task automatic step(input logic wv, input logic [DW-1:0] wd, input logic rr);
    logic acc, pop, free_k, full_k, ovf_known, ovf_exp;
    logic [DW-1:0] exp_head;
    i_wvalid = wv; i_wdata = wd; i_rready = rr;
    #1;
    free_k = (q.size() < DPTH);
    full_k = (q.size() == DPTH + OBUF);
    if (free_k) check_val("wready_not_full", o_wready, 32'd1);
    if (full_k) check_val("wready_full", o_wready, 32'd0);
    if (q.size() == 0) check_val("rvalid_when_empty", o_rvalid, 32'd0);
    if (stall_r) begin
      check_val("rvalid_held_stall", o_rvalid, 32'd1);
      check_val("rdata_held_stall", o_rdata, stall_data);
    end
    acc = wv & o_wready;
    pop = rr & o_rvalid;
    pre_rvalid = o_rvalid;
    if (pop && q.size() > 0) begin
      exp_head = q.pop_front();
      check_val("rdata_order", o_rdata, exp_head);
    end
    stall_r = o_rvalid & ~rr;
    stall_data = o_rdata;
    if (acc) q.push_back(wd);
    ovf_known = !wv || free_k || full_k;
    ovf_exp = wv & full_k;
    @(posedge i_clk);
    #2;
    check_val("data_cnt", 32'(o_data_cnt), 32'(q.size()));
    if (ovf_known) check_val("overflow", o_overflow, 32'(ovf_exp));
    last_acc = acc;
    if (acc) n_written++;
    if (pop) n_popped++;
  endtask

  task automatic do_reset();
    i_wvalid = 1'b0; i_rready = 1'b0;
    i_rst_n = 1'b0;
    #1;
    check_val("rst_rvalid", o_rvalid, 32'd0);
    check_val("rst_data_cnt", 32'(o_data_cnt), 32'd0);
    check_val("rst_wready", o_wready, 32'd1);
    check_val("rst_mem_rd", o_mem_rd, 32'd0);
    check_val("rst_overflow", o_overflow, 32'd0);
    q.delete();
    stall_r = 1'b0;
    repeat (2) @(posedge i_clk);
    #2;
    i_rst_n = 1'b1;
  endtask

  task automatic drain(input int bound);
    int n;
    n = 0;
    while (q.size() > 0 && n < bound) begin
      step(1'b0, '0, 1'b1);
      n++;
    end
    check_val("drain_done", 32'(q.size()), 32'd0);
  endtask

  initial begin
    int guard, bubbles;
    logic started;
    #2;
    do_reset();

    // Single word latency and value.
    step(1'b1, 32'hA5A5_0001, 1'b0);
    repeat (4) step(1'b0, '0, 1'b0);
    check_val("t1_rvalid_early", o_rvalid, 32'd0);
    repeat (2) step(1'b0, '0, 1'b0);
    check_val("t1_rvalid", o_rvalid, 32'd1);
    check_val("t1_rdata", o_rdata, 32'hA5A5_0001);
    check_val("t1_data_cnt", 32'(o_data_cnt), 32'd1);
    drain(20);

    // Fill to capacity with no consumer, then hit the full boundary.
    do_reset();
    n_written = 0; guard = 0;
    do begin
      step(1'b1, 32'hB000_0000 + 32'(n_written), 1'b0);
      guard++;
    end while (last_acc && guard < 1200);
    check_val("t2_accepted", 32'(n_written), 32'(DPTH + OBUF));
    check_val("t2_wready", o_wready, 32'd0);
    check_val("t2_overflow", o_overflow, 32'd1);
    check_val("t2_data_cnt", 32'(o_data_cnt), 32'd1030);
    step(1'b0, '0, 1'b0);
    check_val("t2_overflow_clear", o_overflow, 32'd0);
    drain(1200);

    // Streaming across pointer wrap: no bubbles once data starts flowing.
    do_reset();
    n_written = 0; n_popped = 0; guard = 0; bubbles = 0; started = 1'b0;
    while (n_popped < 3000 && guard < 3300) begin
      step(n_written < 3000, 32'hC000_0000 + 32'(n_written), 1'b1);
      if (pre_rvalid) started = 1'b1;
      else if (started && n_popped < 3000) bubbles++;
      guard++;
    end
    check_val("t3_popped", 32'(n_popped), 32'd3000);
    check_val("t3_bubbles", 32'(bubbles), 32'd0);

    // Random traffic with 50% consumer backpressure.
    do_reset();
    n_written = 0; n_popped = 0; guard = 0;
    while (n_popped < 5000 && guard < 30000) begin
      step((n_written < 5000) && ($urandom_range(0, 3) != 0), $urandom, $urandom_range(0, 1) == 1);
      guard++;
    end
    check_val("t4_popped", 32'(n_popped), 32'd5000);
    check_val("t4_empty", 32'(o_data_cnt), 32'd0);

    // Reset while reads are in flight and words are buffered.
    do_reset();
    for (int i = 0; i < 5; i++) step(1'b1, 32'hD000_0000 + 32'(i), 1'b0);
    repeat (2) step(1'b0, '0, 1'b0);
    check_val("t5_pre_rvalid", o_rvalid, 32'd1);
    check_val("t5_pre_cnt", 32'(o_data_cnt), 32'd5);
    do_reset();
    for (int i = 0; i < 4; i++) step(1'b1, 32'hE000_0000 + 32'(i), 1'b0);
    drain(40);

    // Simultaneous accept and pop with one word in memory and one buffered.
    do_reset();
    step(1'b1, 32'hF000_0000, 1'b0);
    guard = 0;
    while (!o_rvalid && guard < 20) begin
      step(1'b0, '0, 1'b0);
      guard++;
    end
    check_val("t6_rvalid", o_rvalid, 32'd1);
    step(1'b1, 32'hF000_0001, 1'b0);
    step(1'b1, 32'hF000_0002, 1'b1);
    check_val("t6_cnt", 32'(o_data_cnt), 32'd2);
    drain(40);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
